max_detection_tx: RTL and testbench
===================================

MAX_DETECTION_TX -- requirements
Module: max_detection_tx

Interface
REQ-001 The module SHALL have exactly one clock and SHALL use asynchronous, active-low reset.
REQ-002 clk  input  1  Clock; internal state and handshake outputs update on the rising edge; the serial outputs launch on the falling edge.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 load  input  1  Frame request; sampled on the rising edge.
REQ-005 data  input  31  Frame payload, sent LSB first; only bits [nbits-1:0] are used.
REQ-006 nbits  input  5  Frame length in bits, 1..31; value 0 is illegal.
REQ-007 start  output  1  High for exactly the first bit period of each frame.
REQ-008 dout  output  1  Serial data bit.
REQ-009 busy  output  1  A frame is in transmission.
REQ-010 done  output  1  One-cycle pulse at frame completion.
REQ-011 exp_len  output  5  Longest run of consecutive 1s in the last completed frame.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and SEND, and busy SHALL equal (state==SEND).
REQ-013 On rising edge k, when state=IDLE, load=1 and nbits!=0, the module SHALL capture data and nbits into shadow registers, clear the bit index, run counter and max counter, and enter SEND.
REQ-014 A load with nbits=0, or any load sampled while busy=1, SHALL be ignored with no state change.
REQ-015 start and dout SHALL be registered on the falling edge of clk from the rising-edge state, so each bit is stable across the following rising edge.
REQ-016 At falling edge k+0.5 the module SHALL drive start=1 and dout=data[0].
REQ-017 For i = 1..N-1, at falling edge k+i+0.5 the module SHALL drive dout=data[i] and start=0.
REQ-018 At each rising edge in SEND, the module SHALL advance the bit index, update the run counter (increment on a 1 bit, clear on a 0 bit), and keep max = max(max, run).
REQ-019 At rising edge k+N, the module SHALL return to IDLE, assert done=1 for that cycle only, and load exp_len with the final max including the last bit.
REQ-020 While in IDLE, start and dout SHALL be 0 from the next falling edge onward.
REQ-021 exp_len SHALL hold its value until the next done; since N<=31 it cannot overflow, so no saturation is needed.
REQ-022 The earliest accepted next load SHALL be at rising edge k+N+1, giving a minimum of one idle bit between frames.
REQ-023 Changes to data or nbits while busy SHALL NOT affect the frame in flight.

Reset
REQ-024 When rst_n=0, the module SHALL immediately force state=IDLE and start=dout=busy=done=0, exp_len=0, and clear all counters and shadow registers, independent of clk.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after rst_n rises, the module SHALL accept load on the first rising edge.

Verification
REQ-026 data=0x000000F3, nbits=8, load at edge k -> dout=1,1,0,0,1,1,1,1, start high only on the first bit, done at k+8, exp_len=4.
REQ-027 data=0x7FFFFFFF, nbits=31 -> 31 ones, busy high for 31 cycles, exp_len=31.
REQ-028 data=0x7FFFFFF0, nbits=4 -> dout=0,0,0,0, exp_len=0 (upper bits ignored).
REQ-029 load with nbits=0 -> busy stays 0, no start, no done, exp_len unchanged.
REQ-030 load pulsed during busy with different data -> frame in flight unchanged; a load at k+N+1 starts a new frame with start on the falling edge that follows.
REQ-031 rst_n low during bit 5 of a 12-bit frame -> all outputs 0 within the same cycle, no done; a subsequent frame is sent correctly.

Source files
------------

// File: rtl/max_detection_tx_if.sv
// Bundle of frame request and serial transmit signals for max_detection_tx.
//   load    : frame request (master -> slave)
//   data    : 31-bit payload, LSB first (master -> slave)
//   nbits   : frame length 1..31 (master -> slave)
//   start   : high during the first bit period of a frame (slave -> master)
//   dout    : serial data bit (slave -> master)
//   busy    : frame in transmission (slave -> master)
//   done    : one-cycle pulse at frame completion (slave -> master)
//   exp_len : longest run of 1s in the last completed frame (slave -> master)
interface max_detection_tx_if;
  logic        load;
  logic [30:0] data;
  logic [4:0]  nbits;
  logic        start;
  logic        dout;
  logic        busy;
  logic        done;
  logic [4:0]  exp_len;

  modport master (
    output load, data, nbits,
    input  start, dout, busy, done, exp_len
  );

  modport slave (
    input  load, data, nbits,
    output start, dout, busy, done, exp_len
  );
endinterface

// File: rtl/max_detection_tx.sv
// Serial frame transmitter that also measures the longest run of consecutive
// 1s in each frame it sends.
//   clk   : clock; state updates on rising edge, serial outputs on falling edge
//   rst_n : asynchronous active-low reset
//   bus   : max_detection_tx_if.slave (load/data/nbits in;
//           start/dout/busy/done/exp_len out)
module max_detection_tx (
  input  logic                clk,
  input  logic                rst_n,
  max_detection_tx_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [30:0] data_q, data_d;
  logic [4:0]  nbits_q, nbits_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  run_q, run_d;
  logic [4:0]  max_q, max_d;
  logic [4:0]  exp_len_q, exp_len_d;
  logic        done_q, done_d;
  logic        start_q, dout_q;

  logic        cur_bit;
  logic [4:0]  run_next;
  logic [4:0]  max_next;

  assign cur_bit  = data_q[idx_q];
  assign run_next = cur_bit ? 5'(run_q + 5'd1) : 5'd0;
  assign max_next = (run_next > max_q) ? run_next : max_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    nbits_d   = nbits_q;
    idx_d     = idx_q;
    run_d     = run_q;
    max_d     = max_q;
    exp_len_d = exp_len_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load && (bus.nbits != 5'd0)) begin
          state_d = StSend;
          data_d  = bus.data;
          nbits_d = bus.nbits;
          idx_d   = 5'd0;
          run_d   = 5'd0;
          max_d   = 5'd0;
        end
      end
      StSend: begin
        idx_d = 5'(idx_q + 5'd1);
        run_d = run_next;
        max_d = max_next;
        // The edge that consumes the last bit also publishes the result.
        if (idx_q == 5'(nbits_q - 5'd1)) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          exp_len_d = max_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      nbits_q   <= '0;
      idx_q     <= '0;
      run_q     <= '0;
      max_q     <= '0;
      exp_len_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      nbits_q   <= nbits_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      max_q     <= max_d;
      exp_len_q <= exp_len_d;
      done_q    <= done_d;
    end
  end

  // Serial outputs launch half a cycle after the state they reflect, so each
  // bit is stable across the rising edge that consumes it.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      start_q <= (state_q == StSend) && (idx_q == 5'd0);
      dout_q  <= (state_q == StSend) ? cur_bit : 1'b0;
    end
  end

  assign bus.start   = start_q;
  assign bus.dout    = dout_q;
  assign bus.busy    = (state_q == StSend);
  assign bus.done    = done_q;
  assign bus.exp_len = exp_len_q;

endmodule

// File: tb/tb_max_detection_tx.sv
module tb_max_detection_tx;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   last_exp;

  max_detection_tx_if bus ();

  max_detection_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] data;
    int          nbits;
    int          exp_len;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: longest run of 1s over the low nbits of data.
  function automatic int longest_run(input logic [30:0] d, input int n);
    int run = 0;
    int best = 0;
    for (int i = 0; i < n; i++) begin
      run  = d[i] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    return best;
  endfunction

  // Sends one frame and checks every bit period. Data/nbits are scrambled
  // while busy; with noise set, spurious loads are also issued mid-frame.
  task automatic send_frame(input logic [30:0] d, input int n, input int exp_len,
                            input bit noise);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.data  = d;
    bus.nbits = 5'(n);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    chk("busy_after_load", int'(bus.busy), 1);
    chk("done_after_load", int'(bus.done), 0);
    for (int i = 0; i < n; i++) begin
      bus.data  = 31'($urandom);
      bus.nbits = 5'($urandom);
      bus.load  = noise ? 1'($urandom) : 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("dout_bit%0d", i), int'(bus.dout), int'(d[i]));
      chk($sformatf("start_bit%0d", i), int'(bus.start), (i == 0) ? 1 : 0);
      chk($sformatf("busy_bit%0d", i), int'(bus.busy), (i < n - 1) ? 1 : 0);
      chk($sformatf("done_bit%0d", i), int'(bus.done), (i == n - 1) ? 1 : 0);
      if (i < n - 1) chk("exp_len_hold", int'(bus.exp_len), last_exp);
    end
    bus.load = 1'b0;
    chk("exp_len", int'(bus.exp_len), exp_len);
    last_exp = exp_len;
    @(negedge clk);
    #1;
    chk("idle_start", int'(bus.start), 0);
    chk("idle_dout", int'(bus.dout), 0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [30:0] rd;
    int          rn;
    checks   = 0;
    errors   = 0;
    last_exp = 0;
    rst_n     = 1'b0;
    bus.load  = 1'b0;
    bus.data  = '0;
    bus.nbits = '0;

    vecs[0] = '{31'h000000F3, 8, 4};
    vecs[1] = '{31'h7FFFFFFF, 31, 31};
    vecs[2] = '{31'h7FFFFFF0, 4, 0};
    vecs[3] = '{31'h00000001, 1, 1};
    vecs[4] = '{31'h00000000, 5, 0};
    vecs[5] = '{31'h00005555, 16, 1};
    vecs[6] = '{31'h000F0F07, 24, 4};
    vecs[7] = '{31'h40000000, 31, 1};
    vecs[8] = '{31'h3FFFFFFF, 30, 30};

    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_start", int'(bus.start), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_exp_len", int'(bus.exp_len), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed table, back to back (next load at k+N+1).
    foreach (vecs[i]) send_frame(vecs[i].data, vecs[i].nbits, vecs[i].exp_len, 1'b0);

    // Zero-length request is ignored.
    @(negedge clk);
    bus.load  = 1'b1;
    bus.data  = 31'h7FFFFFFF;
    bus.nbits = 5'd0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("nb0_busy", int'(bus.busy), 0);
      chk("nb0_done", int'(bus.done), 0);
      chk("nb0_exp_len", int'(bus.exp_len), last_exp);
      @(negedge clk);
      #1;
      chk("nb0_start", int'(bus.start), 0);
    end
    bus.load = 1'b0;

    // Loads while busy must not disturb the frame in flight.
    send_frame(31'h0000A5C3, 16, longest_run(31'h0000A5C3, 16), 1'b1);
    send_frame(31'h00000FF0, 12, 8, 1'b1);

    // Reset during bit 5 of a 12-bit frame.
    @(negedge clk);
    bus.load  = 1'b1;
    bus.data  = 31'h00000FFF;
    bus.nbits = 5'd12;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    chk("pre_rst_dout", int'(bus.dout), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_start", int'(bus.start), 0);
    chk("midrst_dout", int'(bus.dout), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_exp_len", int'(bus.exp_len), 0);
    last_exp = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("inrst_done", int'(bus.done), 0);
      chk("inrst_busy", int'(bus.busy), 0);
    end
    #1;
    rst_n = 1'b1;
    send_frame(31'h00000B6D, 12, longest_run(31'h00000B6D, 12), 1'b0);

    // Randomised frames against the reference model.
    for (int t = 0; t < 40; t++) begin
      rd = 31'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd | 31'($urandom) | 31'($urandom);
      rn = $urandom_range(1, 31);
      send_frame(rd, rn, longest_run(rd, rn), 1'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
